// File: rtl/sync_down_counter.sv
// Loadable down counter / interval timer: stops at zero (one-shot) or reloads
// (periodic), with a registered one-cycle terminal-count pulse.
module sync_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] reload;

  // busy is the registered image of state, so binding a checker to busy
  // observes the FSM directly.
  always_ff @(posedge clk) begin
    if (clear) begin
      Q      <= '0;
      reload <= '0;
      tc     <= 1'b0;
      busy   <= 1'b0;
      state  <= IDLE;
    end else if (load) begin
      Q      <= load_value;
      reload <= load_value;
      tc     <= 1'b0;
      if (load_value != '0) begin
        state <= RUN;
        busy  <= 1'b1;
      end else begin
        state <= IDLE;
        busy  <= 1'b0;
      end
    end else if (state == RUN && enable) begin
      if (Q > WIDTH'(1)) begin
        Q  <= Q - WIDTH'(1);
        tc <= 1'b0;
      end else if (auto_reload) begin
        // Q==1 jumps straight to the reload value, so Q never reads 0 here.
        Q  <= reload;
        tc <= 1'b1;
      end else begin
        Q     <= '0;
        tc    <= 1'b1;
        state <= IDLE;
        busy  <= 1'b0;
      end
    end else begin
      tc <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sync_down_counter.sv
// Bench for sync_down_counter: vector table plus hand sequences, checked
// through an expected-value queue.
module tb_sync_down_counter;

  localparam int WIDTH = 4;
  localparam int EW = WIDTH + 2;

  logic             clk;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             enable;
  logic             auto_reload;
  logic [WIDTH-1:0] Q;
  logic             tc;
  logic             busy;

  int tests_run = 0;
  int tests_failed = 0;

  logic [EW-1:0] exp_q[$];

  typedef struct {
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] lv;
    logic             en;
    logic             ar;
    logic [WIDTH-1:0] eq;
    logic             etc;
    logic             ebusy;
    string            name;
  } vec_t;

  vec_t vecs[$];

  sync_down_counter #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .clear       (clear),
    .load        (load),
    .load_value  (load_value),
    .enable      (enable),
    .auto_reload (auto_reload),
    .Q           (Q),
    .tc          (tc),
    .busy        (busy)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic v(input logic c, input logic l, input int lv, input logic en,
                   input logic ar, input int eq, input logic etc,
                   input logic eb, input string name);
    vec_t x;
    x.clear = c; x.load = l; x.lv = WIDTH'(lv); x.en = en; x.ar = ar;
    x.eq = WIDTH'(eq); x.etc = etc; x.ebusy = eb; x.name = name;
    vecs.push_back(x);
  endtask

  // driver: apply one cycle of inputs, push expectation, compare after edge
  task automatic step(input logic c, input logic l, input logic [WIDTH-1:0] lv,
                      input logic en, input logic ar,
                      input logic [WIDTH-1:0] eq, input logic etc,
                      input logic eb, input string name);
    logic [EW-1:0] got;
    logic [EW-1:0] want;
    clear = c; load = l; load_value = lv; enable = en; auto_reload = ar;
    exp_q.push_back({eq, etc, eb});
    @(posedge clk);
    #1;
    got  = {Q, tc, busy};
    want = exp_q.pop_front();
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got Q=%0d tc=%0b busy=%0b, expected Q=%0d tc=%0b busy=%0b",
               name, got[EW-1:2], got[1], got[0], want[EW-1:2], want[1], want[0]);
    end
  endtask

  initial begin
    clear = 1'b1; load = 1'b0; load_value = '0; enable = 1'b0; auto_reload = 1'b0;

    // reset, with load asserted underneath clear
    v(1, 1, 9, 1, 0, 0, 0, 0, "reset_0");
    v(1, 1, 9, 1, 0, 0, 0, 0, "reset_1");
    v(0, 0, 0, 0, 0, 0, 0, 0, "reset_release");
    v(0, 0, 0, 1, 0, 0, 0, 0, "idle_enable");
    // one-shot N=5
    v(0, 1, 5, 1, 0, 5, 0, 1, "os_load5");
    v(0, 0, 0, 1, 0, 4, 0, 1, "os_4");
    v(0, 0, 0, 1, 0, 3, 0, 1, "os_3");
    v(0, 0, 0, 1, 0, 2, 0, 1, "os_2");
    v(0, 0, 0, 1, 0, 1, 0, 1, "os_1");
    v(0, 0, 0, 1, 0, 0, 1, 0, "os_tc");
    // enable gating from 6
    v(0, 1, 6, 1, 0, 6, 0, 1, "gate_load6");
    v(0, 0, 0, 1, 0, 5, 0, 1, "gate_e1");
    v(0, 0, 0, 0, 0, 5, 0, 1, "gate_e0");
    v(0, 0, 0, 1, 0, 4, 0, 1, "gate_e1b");
    v(0, 0, 0, 1, 0, 3, 0, 1, "gate_e1c");
    v(0, 0, 0, 0, 0, 3, 0, 1, "gate_e0b");
    v(0, 0, 0, 0, 0, 3, 0, 1, "gate_e0c");
    v(0, 0, 0, 1, 0, 2, 0, 1, "gate_end2");
    // load 0 from RUN
    v(0, 1, 0, 1, 0, 0, 0, 0, "load0");
    v(0, 0, 0, 1, 0, 0, 0, 0, "load0_hold");
    // load on the terminal-count edge suppresses tc
    v(0, 1, 2, 1, 0, 2, 0, 1, "ltc_load2");
    v(0, 0, 0, 1, 0, 1, 0, 1, "ltc_1");
    v(0, 1, 7, 1, 0, 7, 0, 1, "ltc_load7");
    v(0, 0, 0, 1, 0, 6, 0, 1, "ltc_6");
    // clear mid-count, then enable without load stays at 0
    v(0, 1, 10, 1, 0, 10, 0, 1, "mid_load10");
    v(0, 0, 0, 1, 0, 9, 0, 1, "mid_9");
    v(0, 0, 0, 1, 0, 8, 0, 1, "mid_8");
    v(0, 0, 0, 1, 0, 7, 0, 1, "mid_7");
    v(0, 0, 0, 1, 0, 6, 0, 1, "mid_6");
    v(0, 0, 0, 1, 0, 5, 0, 1, "mid_5");
    v(0, 0, 0, 1, 0, 4, 0, 1, "mid_4");
    v(1, 0, 0, 1, 0, 0, 0, 0, "mid_clear");
    v(0, 0, 0, 1, 1, 0, 0, 0, "mid_after_0");
    v(0, 0, 0, 1, 1, 0, 0, 0, "mid_after_1");
    // auto_reload only matters at the terminal count
    v(0, 1, 3, 1, 1, 3, 0, 1, "ar_load3");
    v(0, 0, 0, 1, 0, 2, 0, 1, "ar_2");
    v(0, 0, 0, 1, 0, 1, 0, 1, "ar_1");
    v(0, 0, 0, 1, 0, 0, 1, 0, "ar_tc_oneshot");
    v(0, 1, 2, 1, 0, 2, 0, 1, "ar_load2");
    v(0, 0, 0, 1, 1, 1, 0, 1, "ar_1b");
    v(0, 0, 0, 1, 1, 2, 1, 1, "ar_tc_reload");
    v(0, 0, 0, 1, 1, 1, 0, 1, "ar_1c");

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].clear, vecs[i].load, vecs[i].lv, vecs[i].en, vecs[i].ar,
           vecs[i].eq, vecs[i].etc, vecs[i].ebusy, vecs[i].name);

    // one-shot expiry, then Q stays 0 with enable high
    step(0, 1, 4'd5, 1, 0, 4'd5, 0, 1, "os2_load5");
    for (int k = 4; k >= 1; k--)
      step(0, 0, 4'd0, 1, 0, WIDTH'(k), 0, 1, "os2_count");
    step(0, 0, 4'd0, 1, 0, 4'd0, 1, 0, "os2_tc");
    for (int k = 0; k < 10; k++)
      step(0, 0, WIDTH'($urandom_range(0, 15)), 1, 1'($urandom_range(0, 1)),
           4'd0, 0, 0, "os2_stay0");

    // periodic N=3: 12 enabled cycles, tc on every third
    step(0, 1, 4'd3, 1, 1, 4'd3, 0, 1, "per_load3");
    for (int k = 1; k <= 12; k++) begin
      logic [WIDTH-1:0] eq;
      eq = (k % 3 == 1) ? 4'd2 : (k % 3 == 2) ? 4'd1 : 4'd3;
      step(0, 0, 4'd0, 1, 1, eq, (k % 3 == 0), 1, "per_cycle");
    end

    // all-ones load: 15 enabled cycles to tc, with random disabled gaps
    step(0, 1, 4'd15, 1, 0, 4'd15, 0, 1, "max_load15");
    for (int k = 14; k >= 0; k--) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++)
        step(0, 0, 4'd0, 0, 0, WIDTH'(k + 1), 0, 1, "max_hold");
      step(0, 0, 4'd0, 1, 0, WIDTH'(k), (k == 0), (k != 0), "max_count");
    end

    // N=1 periodic: Q stays 1, tc on every enabled cycle
    step(0, 1, 4'd1, 1, 1, 4'd1, 0, 1, "n1_load1");
    step(0, 0, 4'd0, 1, 1, 4'd1, 1, 1, "n1_tc0");
    step(0, 0, 4'd0, 1, 1, 4'd1, 1, 1, "n1_tc1");
    step(0, 0, 4'd0, 0, 1, 4'd1, 0, 1, "n1_hold");
    step(0, 0, 4'd0, 1, 1, 4'd1, 1, 1, "n1_tc2");
    step(0, 0, 4'd0, 1, 0, 4'd0, 1, 0, "n1_stop");
    step(0, 0, 4'd0, 1, 0, 4'd0, 0, 0, "n1_idle");

    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
